// File: rtl/uart_frame_parser_pkg.sv
// Shared types for the UART command-frame parser: state encoding, byte type, SYNC default.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_frame_pkg;

   typedef logic [7:0] byte_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_LEN,
      ST_DATA,
      ST_CHK,
      ST_DONE
   } frame_state_t;

   localparam byte_t SYNC_BYTE_DEF = 8'hA5;

   // States in which the inter-byte gap is being policed
   function automatic logic is_gap_state(input frame_state_t s);
      return (s == ST_CMD) || (s == ST_LEN) || (s == ST_DATA) || (s == ST_CHK);
   endfunction

endpackage

// File: rtl/uart_gap_timer.sv
// Inter-byte gap counter: counts enabled idle cycles, flags the cycle the count reaches TIMEOUT_CYC.
// Latency: expired is combinational from the count; count updates every clock.
// Backpressure: none; clear or disable restarts the count from zero.
module uart_gap_timer #(
   parameter int TIMEOUT_CYC = 4096
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

   logic [CW-1:0] cnt;

   // Count enabled cycles since the last clear; held at zero while disabled
   always_ff @(posedge clk) begin
      if (rst || clear || !enable) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   // Expiry is the cycle whose closing edge would be the TIMEOUT_CYC-th silent edge
   assign expired = enable && (cnt == CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/uart_frame_parser.sv
// Assembles SYNC/CMD/LEN/payload[/CHK] frames from UART bytes and holds them for a consumer.
// Latency: out_frame_valid rises one cycle after the final byte strobe; error strobes likewise.
// Backpressure: none upstream; bytes arriving while a frame is held are dropped with out_overrun.
// Option: UART_FRAME_CHKSUM_EN adds the trailing XOR checksum byte and out_err_chk.
module uart_frame_parser
   import uart_frame_pkg::*;
#(
   parameter int    MAX_LEN     = 16,
   parameter int    TIMEOUT_CYC = 4096,
   parameter byte_t SYNC_BYTE   = SYNC_BYTE_DEF,
   localparam int   LW          = $clog2(MAX_LEN + 1),
   localparam int   AW          = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
   input  logic          in_clk,
   input  logic          in_rst,
   input  logic          in_rx_ready,
   input  logic [7:0]    in_rx_data,
   output logic          out_frame_valid,
   output logic [7:0]    out_cmd,
   output logic [LW-1:0] out_len,
   input  logic [AW-1:0] in_rd_addr,
   output logic [7:0]    out_rd_data,
   input  logic          in_frame_ack,
   output logic          out_err_len,
   output logic          out_err_chk,
   output logic          out_err_timeout,
   output logic          out_overrun
);

`ifdef UART_FRAME_CHKSUM_EN
   localparam frame_state_t ST_TAIL    = ST_CHK;
   localparam logic         TAIL_VALID = 1'b0;
   byte_t chk_q;
   logic  err_chk_q;
`else
   localparam frame_state_t ST_TAIL    = ST_DONE;
   localparam logic         TAIL_VALID = 1'b1;
`endif

   frame_state_t  state;
   byte_t         cmd_q;
   logic [LW-1:0] len_q;
   logic [AW-1:0] wr_idx;
   logic          valid_q;
   logic          err_len_q;
   logic          err_to_q;
   logic          overrun_q;
   byte_t         payload [MAX_LEN];
   logic          gap_run;
   logic          gap_expired;
   logic          last_byte;

   assign gap_run   = is_gap_state(state);
   assign last_byte = (int'(wr_idx) == int'(len_q) - 1);

   uart_gap_timer #(
      .TIMEOUT_CYC(TIMEOUT_CYC)
   ) u_gap_timer (
      .clk    (in_clk),
      .rst    (in_rst),
      .clear  (in_rx_ready),
      .enable (gap_run),
      .expired(gap_expired)
   );

   // Frame FSM with registered handshake and one-cycle error strobes; a byte beats a same-cycle expiry
   always_ff @(posedge in_clk) begin
      if (in_rst) begin
         state     <= ST_IDLE;
         cmd_q     <= '0;
         len_q     <= '0;
         wr_idx    <= '0;
         valid_q   <= 1'b0;
         err_len_q <= 1'b0;
         err_to_q  <= 1'b0;
         overrun_q <= 1'b0;
`ifdef UART_FRAME_CHKSUM_EN
         err_chk_q <= 1'b0;
`endif
      end else begin
         err_len_q <= 1'b0;
         err_to_q  <= 1'b0;
         overrun_q <= 1'b0;
`ifdef UART_FRAME_CHKSUM_EN
         err_chk_q <= 1'b0;
`endif
         if (gap_run && !in_rx_ready && gap_expired) begin
            err_to_q <= 1'b1;
            state    <= ST_IDLE;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (in_rx_ready && (in_rx_data == SYNC_BYTE)) begin
                     state <= ST_CMD;
                  end
               end
               ST_CMD: begin
                  if (in_rx_ready) begin
                     cmd_q <= in_rx_data;
                     state <= ST_LEN;
                  end
               end
               ST_LEN: begin
                  if (in_rx_ready) begin
                     if (int'(in_rx_data) > MAX_LEN) begin
                        err_len_q <= 1'b1;
                        state     <= ST_IDLE;
                     end else begin
                        len_q  <= in_rx_data[LW-1:0];
                        wr_idx <= '0;
                        if (in_rx_data == 8'd0) begin
                           state   <= ST_TAIL;
                           valid_q <= TAIL_VALID;
                        end else begin
                           state <= ST_DATA;
                        end
                     end
                  end
               end
               ST_DATA: begin
                  if (in_rx_ready) begin
                     wr_idx <= wr_idx + 1'b1;
                     if (last_byte) begin
                        state   <= ST_TAIL;
                        valid_q <= TAIL_VALID;
                     end
                  end
               end
`ifdef UART_FRAME_CHKSUM_EN
               ST_CHK: begin
                  if (in_rx_ready) begin
                     if (in_rx_data == chk_q) begin
                        state   <= ST_DONE;
                        valid_q <= 1'b1;
                     end else begin
                        err_chk_q <= 1'b1;
                        state     <= ST_IDLE;
                     end
                  end
               end
`endif
               ST_DONE: begin
                  if (in_rx_ready) begin
                     overrun_q <= 1'b1;
                  end
                  if (in_frame_ack) begin
                     valid_q <= 1'b0;
                     state   <= ST_IDLE;
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

`ifdef UART_FRAME_CHKSUM_EN
   // Running XOR over CMD, LEN and payload; a SYNC in IDLE restarts it
   always_ff @(posedge in_clk) begin
      if (in_rst) begin
         chk_q <= '0;
      end else if (in_rx_ready) begin
         if (state == ST_IDLE) begin
            chk_q <= '0;
         end else if ((state == ST_CMD) || (state == ST_LEN) || (state == ST_DATA)) begin
            chk_q <= chk_q ^ in_rx_data;
         end
      end
   end

   assign out_err_chk = err_chk_q;
`else
   assign out_err_chk = 1'b0;
`endif

   // Payload store, written only while collecting data so a held frame stays intact
   always_ff @(posedge in_clk) begin
      if (!in_rst && (state == ST_DATA) && in_rx_ready) begin
         payload[wr_idx] <= in_rx_data;
      end
   end

   assign out_rd_data     = payload[in_rd_addr];
   assign out_frame_valid = valid_q;
   assign out_cmd         = cmd_q;
   assign out_len         = len_q;
   assign out_err_len     = err_len_q;
   assign out_err_timeout = err_to_q;
   assign out_overrun     = overrun_q;

endmodule
